ws2812_frame_ram: RTL
=====================

WS2812_FRAME_RAM -- requirements
Module: ws2812_frame_ram

Interface
REQ-001 SHALL have parameter LED_COUNT, default 64: number of pixels held.
REQ-002 SHALL have parameter CHANNELS, default 3: bytes per pixel (3 = GRB, 4 = GRBW).
REQ-003 SHALL have parameter DATA_W, default 8: bits per channel byte.
REQ-004 SHALL derive DEPTH = LED_COUNT*CHANNELS and ADDR_W = max(1, clog2(DEPTH)).
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 addr  in  ADDR_W  host byte address, pixel*CHANNELS + channel.
REQ-008 write_data  in  DATA_W  host write byte.
REQ-009 we  in  1  host write strobe, one byte per cycle.
REQ-010 read_data  out  DATA_W  host read byte, for addr sampled one cycle earlier.
REQ-011 clear  in  1  pulse; zero the whole frame.
REQ-012 start  in  1  pulse; stream the frame to the serializer.
REQ-013 busy  out  1  high in CLEAR or STREAM.
REQ-014 s_valid / s_data[DATA_W] / s_last  out  stream byte, valid, final-byte flag.
REQ-015 s_ready  in  1  serializer accepts byte when s_valid && s_ready.

Function
REQ-016 SHALL implement FSM IDLE, CLEAR, STREAM; reset state IDLE.
REQ-017 IDLE: clear -> CLEAR; else start -> STREAM; both high in the same cycle -> CLEAR, start dropped.
REQ-018 CLEAR: write 0 to one address per cycle, 0..DEPTH-1; after DEPTH-1 is written -> IDLE; busy falls the cycle after the last write.
REQ-019 STREAM: present bytes 0..DEPTH-1 in order; s_last high only with byte DEPTH-1; the handshake on the last byte -> IDLE.
REQ-020 First s_valid SHALL rise no later than 2 cycles after start is sampled; with s_ready held high, throughput SHALL be one byte per cycle (DEPTH+2 cycles per frame max).
REQ-021 s_valid, once high, SHALL stay high and s_data/s_last stable until accepted.
REQ-022 start or clear while busy SHALL be ignored.
REQ-023 Host we SHALL be ignored in CLEAR; in STREAM it SHALL be ignored unless DOUBLE_BUF (REQ-030) is on.
REQ-024 we with addr >= DEPTH SHALL be ignored; a read with addr >= DEPTH SHALL return 0.
REQ-025 Host read latency SHALL be 1 cycle, in every state.
REQ-026 Address counters SHALL not wrap: terminal count DEPTH-1 ends the operation.

Reset
REQ-027 Reset SHALL force IDLE and busy=0, s_valid=0, s_last=0, s_data=0, read_data=0, all counters=0.
REQ-028 Reset mid-CLEAR or mid-STREAM SHALL abort with no further RAM writes or stream bytes; the RAM array is not reset and keeps any values already written.
REQ-029 Deassertion SHALL be honoured on the next rising edge; the first operation may start on the edge after that.

Configuration
REQ-030 With macro WS2812_FRAME_RAM_DOUBLE_BUF_EN: two frame banks. Host reads and writes target the back bank, the stream reads the front bank, and the banks swap on the cycle STREAM -> IDLE. Host writes are accepted during STREAM. clear zeroes the back bank only.
REQ-031 Without the macro: single bank; behaviour exactly REQ-016..026.

Structure
REQ-032 Shared package ws2812_pkg SHALL hold the FSM state enum, default LED_COUNT/CHANNELS/DATA_W constants, and the DEPTH/ADDR_W helper functions.
REQ-033 Sub-module ws2812_bram SHALL be the storage: single port, synchronous read, 1-cycle latency. Instantiate it once, or twice under DOUBLE_BUF.

Verification
REQ-034 Setup: LED_COUNT=4, CHANNELS=3. Write 0xAB to addr 5, then read addr 5 -> read_data=0xAB one cycle later.
REQ-035 Write 0x01..0x0C to addr 0..11, then pulse start with s_ready=1 -> 12 bytes 0x01..0x0C on consecutive cycles; s_last only on 0x0C; busy low afterwards.
REQ-036 During a stream, toggle s_ready 1-0-0-1 -> no byte lost or duplicated; s_data is held while s_ready=0.
REQ-037 Pulse clear, with we=1 on addr 3 during CLEAR -> busy high 12 cycles; all 12 addresses then read 0.
REQ-038 Assert rst_n=0 during STREAM byte 6 -> s_valid=0 on that edge, state IDLE; a following stream reproduces the original contents.
REQ-039 With WS2812_FRAME_RAM_DOUBLE_BUF_EN: write during a stream -> the current stream is unchanged; the next stream shows the new data.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and sizing helpers for the WS2812 frame buffer.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    localparam int DEF_LED_COUNT = 64;
    localparam int DEF_CHANNELS  = 3;
    localparam int DEF_DATA_W    = 8;

    function automatic int calc_depth(input int led_count, input int channels);
        return led_count * channels;
    endfunction

    function automatic int calc_addr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ws2812_bram.sv
// Frame storage: one write port, two synchronous read ports (host, stream),
// 1-cycle read latency. Out-of-range reads return 0, out-of-range writes drop.
module ws2812_bram #(
    parameter int DEPTH  = 192,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_a_d, rdata_a_q;
    logic [DATA_W-1:0] rdata_b_d, rdata_b_q;

    // NOTE: the array carries no reset so it maps onto block RAM; only the read registers reset.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_W)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a_d = '0;
        rdata_b_d = '0;
        if ({1'b0, raddr_a} < DEPTH_W) rdata_a_d = mem[raddr_a];
        if ({1'b0, raddr_b} < DEPTH_W) rdata_b_d = mem[raddr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/ws2812_frame_ram.sv
// WS2812 pixel frame buffer: host byte access, bulk clear, streaming to a serializer.
// Define WS2812_FRAME_RAM_DOUBLE_BUF_EN for front/back banks swapped at end of stream.
module ws2812_frame_ram
    import ws2812_pkg::*;
#(
    parameter int  LED_COUNT = DEF_LED_COUNT,
    parameter int  CHANNELS  = DEF_CHANNELS,
    parameter int  DATA_W    = DEF_DATA_W,
    localparam int DEPTH     = calc_depth(LED_COUNT, CHANNELS),
    localparam int ADDR_W    = calc_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              we,
    output logic [DATA_W-1:0] read_data,
    input  logic              clear,
    input  logic              start,
    output logic              busy,
    output logic              s_valid,
    output logic [DATA_W-1:0] s_data,
    output logic              s_last,
    input  logic              s_ready
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
`ifdef WS2812_FRAME_RAM_DOUBLE_BUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              s_valid_q, s_valid_d;
    logic              s_last_q, s_last_d;
    logic              busy_q, busy_d;
    logic              rd_oor_q, rd_oor_d;

    logic              addr_ok, advance, we_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, stream_raddr;
    logic [DATA_W-1:0] ram_wdata, host_rdata, stream_rdata;

    assign addr_ok = {1'b0, addr} < DEPTH_W;
    assign advance = s_valid_q && s_ready;
    assign we_ok   = we && addr_ok &&
                     (state_q == ST_IDLE || (DBUF && state_q == ST_STREAM));

    // Clear owns the write port outright; host writes only get it otherwise.
    always_comb begin
        ram_we    = we_ok;
        ram_waddr = addr;
        ram_wdata = write_data;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
        end
    end

    // Re-read the presented byte while stalled so s_data holds; prefetch on accept.
    always_comb begin
        stream_raddr = '0;
        if (state_q == ST_STREAM) begin
            stream_raddr = (advance && cnt_q != LAST) ? cnt_q + ADDR_W'(1) : cnt_q;
        end
    end

    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_valid_d = s_valid_q;
        s_last_d  = s_last_q;
        busy_d    = busy_q;
        rd_oor_d  = !addr_ok;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (start) begin
                    state_d   = ST_STREAM;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    s_valid_d = 1'b1;
                    s_last_d  = (LAST == '0);
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_STREAM: begin
                if (advance) begin
                    if (cnt_q == LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        busy_d    = 1'b0;
                        s_valid_d = 1'b0;
                        s_last_d  = 1'b0;
                    end else begin
                        cnt_d    = cnt_q + ADDR_W'(1);
                        s_last_d = ((cnt_q + ADDR_W'(1)) == LAST);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                busy_d    = 1'b0;
                s_valid_d = 1'b0;
                s_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
            busy_q    <= busy_d;
            rd_oor_q  <= rd_oor_d;
        end
    end

`ifdef WS2812_FRAME_RAM_DOUBLE_BUF_EN
    // bank_q names the front (streamed) bank; the host and clear see the other one.
    logic              bank_q, bank_d, rd_bank_q, rd_bank_d;
    logic [DATA_W-1:0] host_rdata_0, host_rdata_1, stream_rdata_0, stream_rdata_1;

    always_comb begin
        bank_d    = bank_q;
        rd_bank_d = ~bank_q;
        if (state_q == ST_STREAM && advance && cnt_q == LAST) bank_d = ~bank_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q    <= 1'b0;
            rd_bank_q <= 1'b1;
        end else begin
            bank_q    <= bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    ws2812_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram_0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we && bank_q),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (addr),
        .rdata_a (host_rdata_0),
        .raddr_b (stream_raddr),
        .rdata_b (stream_rdata_0)
    );

    ws2812_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we && !bank_q),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (addr),
        .rdata_a (host_rdata_1),
        .raddr_b (stream_raddr),
        .rdata_b (stream_rdata_1)
    );

    assign host_rdata   = rd_bank_q ? host_rdata_1 : host_rdata_0;
    assign stream_rdata = bank_q ? stream_rdata_1 : stream_rdata_0;
`else
    ws2812_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (addr),
        .rdata_a (host_rdata),
        .raddr_b (stream_raddr),
        .rdata_b (stream_rdata)
    );
`endif

    assign read_data = rd_oor_q ? '0 : host_rdata;
    assign busy      = busy_q;
    assign s_valid   = s_valid_q;
    assign s_last    = s_last_q;
    assign s_data    = stream_rdata;

endmodule
